// File: rtl/mcs4_bus_master_if.sv
// Shared 4-bit bus, control strobes and core command/response handshake
// between the MCS-4 bus master and the core/chip side.
interface mcs4_bus_master_if;
    logic        sync;
    logic        cl_rom;
    logic        cm_rom;
    logic [3:0]  dbus_out;
    logic [3:0]  dbus_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_pc;
    logic        cmd_io;
    logic        cmd_src;
    logic        cmd_x2_drive;
    logic [3:0]  cmd_x2_data;
    logic        rsp_valid;
    logic [7:0]  rsp_opcode;
    logic [3:0]  rsp_x2_data;
    logic        clr_req;

    modport master (
        output sync, cl_rom, cm_rom, dbus_out, cmd_ready,
               rsp_valid, rsp_opcode, rsp_x2_data,
        input  dbus_in, cmd_valid, cmd_pc, cmd_io, cmd_src,
               cmd_x2_drive, cmd_x2_data, clr_req
    );

    modport slave (
        input  sync, cl_rom, cm_rom, dbus_out, cmd_ready,
               rsp_valid, rsp_opcode, rsp_x2_data,
        output dbus_in, cmd_valid, cmd_pc, cmd_io, cmd_src,
               cmd_x2_drive, cmd_x2_data, clr_req
    );
endinterface

// File: rtl/mcs4_bus_master.sv
// MCS-4 bus master: 8-phase instruction cycle sequencer that drives the fetch
// address, captures the opcode and X2 nibble, and issues cm_rom/cl_rom strobes.
module mcs4_bus_master #(
    parameter logic [11:0] IDLE_ADDR  = 12'hFFF,
    parameter int unsigned CLR_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mcs4_bus_master_if.master bus
);
    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;
    localparam logic [3:0] CLR_LOAD = 4'(CLR_CYCLES);

    logic [2:0]  r_phase;
    logic        r_active;
    logic [11:0] r_pc;
    logic        r_io;
    logic        r_src;
    logic        r_x2_drive;
    logic [3:0]  r_x2_data;
    logic [7:0]  r_opcode;
    logic [3:0]  r_clr_cnt;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_opcode;
    logic [3:0]  r_rsp_x2;

    logic        w_x3;
    logic        w_accept;
    logic [11:0] w_addr;

    assign w_x3     = (r_phase == PH_X3);
    assign w_accept = w_x3 && bus.cmd_valid;
    assign w_addr   = r_active ? r_pc : IDLE_ADDR;

    // Phase counter, cycle state, clear counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= PH_X3;
            r_active     <= 1'b0;
            r_clr_cnt    <= 4'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_opcode <= 8'h00;
            r_rsp_x2     <= 4'h0;
        end else begin
            r_phase     <= r_phase + 3'd1;
            r_rsp_valid <= 1'b0;
            if (w_x3)
                r_active <= bus.cmd_valid;
            if (r_clr_cnt != 4'd0)
                r_clr_cnt <= r_clr_cnt - 4'd1;
            else if (w_x3 && bus.clr_req)
                r_clr_cnt <= CLR_LOAD;
            if (r_phase == PH_X2 && r_active) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_opcode <= r_opcode;
                r_rsp_x2     <= bus.dbus_in;
            end
        end
    end

    // Command payload and opcode nibbles are only meaningful while r_active.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc       <= bus.cmd_pc;
            r_io       <= bus.cmd_io;
            r_src      <= bus.cmd_src;
            r_x2_drive <= bus.cmd_x2_drive;
            r_x2_data  <= bus.cmd_x2_data;
        end
        if (r_phase == PH_M1)
            r_opcode[7:4] <= bus.dbus_in;
        if (r_phase == PH_M2)
            r_opcode[3:0] <= bus.dbus_in;
    end

    always_comb begin
        bus.dbus_out = 4'h0;
        case (r_phase)
            PH_A1:   bus.dbus_out = w_addr[3:0];
            PH_A2:   bus.dbus_out = w_addr[7:4];
            PH_A3:   bus.dbus_out = w_addr[11:8];
            PH_X2:   if (r_active && (r_src || r_x2_drive)) bus.dbus_out = r_x2_data;
            default: bus.dbus_out = 4'h0;
        endcase
    end

    assign bus.cm_rom      = r_active && ((r_phase == PH_M2 && r_io) ||
                                          (r_phase == PH_X2 && r_src));
    assign bus.sync        = w_x3;
    assign bus.cmd_ready   = w_x3;
    assign bus.cl_rom      = (r_clr_cnt != 4'd0);
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_opcode  = r_rsp_opcode;
    assign bus.rsp_x2_data = r_rsp_x2;
endmodule

// File: tb/tb_mcs4_bus_master.sv
// Bench for mcs4_bus_master with a behavioural 4001 ROM/IO chip on the bus.
module tb_mcs4_bus_master;
  localparam logic [11:0] IDLE_ADDR  = 12'hFFF;
  localparam int          CLR_CYCLES = 3;
  localparam logic [3:0]  ROM_ID     = 4'h0;
  localparam logic [3:0]  IO_CHIP    = 4'h2;
  localparam logic [3:0]  IO_MASK    = 4'hF;

  typedef struct packed {
    logic        valid;
    logic [11:0] pc;
    logic        io;
    logic        src;
    logic        drv;
    logic [3:0]  x2d;
    logic        clr;
    logic [3:0]  io_in;
  } cmd_t;

  typedef struct packed {
    cmd_t       c;
    logic [7:0] op;
    logic [3:0] x2;
    logic [3:0] ioo;
  } vec_t;

  logic clk, rst_n;
  int   n_vec, n_err;

  // Reference state: last response and the IO chip's select/output latch.
  logic [7:0] m_op;
  logic [3:0] m_x2, m_sel, m_io_out;

  // Behavioural 4001 chip environment.
  logic [7:0]  rom [256];
  logic [2:0]  ch_ph;
  logic [11:0] ch_addr;
  logic [4:0]  ch_iop;
  logic [3:0]  ch_sel, io_out, io_in, chip_drv;

  mcs4_bus_master_if bus_if ();

  mcs4_bus_master #(.IDLE_ADDR(IDLE_ADDR), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_ph   <= 3'd7;
      ch_addr <= 12'h000;
      ch_iop  <= 5'd0;
      ch_sel  <= 4'h0;
      io_out  <= 4'h0;
    end else begin
      ch_ph <= ch_ph + 3'd1;
      case (ch_ph)
        3'd0: ch_addr[3:0]  <= bus_if.dbus_in;
        3'd1: ch_addr[7:4]  <= bus_if.dbus_in;
        3'd2: ch_addr[11:8] <= bus_if.dbus_in;
        3'd4: ch_iop <= (bus_if.cm_rom && ch_sel == IO_CHIP) ? {1'b1, bus_if.dbus_in} : 5'd0;
        3'd6: begin
          if (bus_if.cm_rom) ch_sel <= bus_if.dbus_in;
          if (ch_iop == 5'h10) io_out <= bus_if.dbus_in & IO_MASK;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    chip_drv = 4'h0;
    if (ch_ph == 3'd3 && ch_addr[11:8] == ROM_ID) chip_drv = rom[ch_addr[7:0]][7:4];
    if (ch_ph == 3'd4 && ch_addr[11:8] == ROM_ID) chip_drv = rom[ch_addr[7:0]][3:0];
    if (ch_ph == 3'd6 && ch_iop == 5'h1A)         chip_drv = io_in & IO_MASK;
  end

  assign bus_if.dbus_in = bus_if.dbus_out | chip_drv;

  task automatic check_b(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cmd_t mkc(logic v, logic [11:0] pc, logic io, logic src, logic drv,
                               logic [3:0] x2d, logic clr, logic [3:0] ioi);
    cmd_t c;
    c.valid = v; c.pc = pc; c.io = io; c.src = src; c.drv = drv;
    c.x2d = x2d; c.clr = clr; c.io_in = ioi;
    return c;
  endfunction

  function automatic vec_t mkv(cmd_t c, logic [7:0] op, logic [3:0] x2, logic [3:0] ioo);
    vec_t v;
    v.c = c; v.op = op; v.x2 = x2; v.ioo = ioo;
    return v;
  endfunction

  task automatic drive(input cmd_t c);
    bus_if.cmd_valid    = c.valid;
    bus_if.cmd_pc       = c.pc;
    bus_if.cmd_io       = c.io;
    bus_if.cmd_src      = c.src;
    bus_if.cmd_x2_drive = c.drv;
    bus_if.cmd_x2_data  = c.x2d;
    bus_if.clr_req      = c.clr;
    io_in               = c.io_in;
  endtask

  task automatic check_reset_values(input string tag);
    check_b({tag, " sync"},      bus_if.sync, 1'b1);
    check_b({tag, " cmd_ready"}, bus_if.cmd_ready, 1'b1);
    check_b({tag, " cl_rom"},    bus_if.cl_rom, 1'b0);
    check_b({tag, " cm_rom"},    bus_if.cm_rom, 1'b0);
    check_v({tag, " dbus_out"},  8'(bus_if.dbus_out), 8'h00);
    check_b({tag, " rsp_valid"}, bus_if.rsp_valid, 1'b0);
    check_v({tag, " rsp_opcode"}, bus_if.rsp_opcode, 8'h00);
    check_v({tag, " rsp_x2"},    8'(bus_if.rsp_x2_data), 8'h00);
  endtask

  // Called just after a negedge in X3: offers c, runs one full instruction
  // cycle and checks every phase against the reference model.
  task automatic do_cycle(input cmd_t c);
    logic [7:0]  e_op;
    logic [3:0]  e_x2, e_db;
    logic [11:0] a;
    logic        rdr, wrr;
    cmd_t        junk;
    a    = c.valid ? c.pc : IDLE_ADDR;
    e_op = (c.pc[11:8] == ROM_ID) ? rom[c.pc[7:0]] : 8'h00;
    rdr  = c.valid && c.io && m_sel == IO_CHIP && e_op[3:0] == 4'hA;
    wrr  = c.valid && c.io && m_sel == IO_CHIP && e_op[3:0] == 4'h0;
    e_x2 = ((c.valid && (c.src || c.drv)) ? c.x2d : 4'h0) | (rdr ? (c.io_in & IO_MASK) : 4'h0);
    drive(c);
    for (int p = 0; p < 8; p++) begin
      @(posedge clk);
      @(negedge clk);
      e_db = 4'h0;
      if (p < 3) e_db = 4'((a >> (4 * p)) & 12'hF);
      else if (p == 6 && c.valid && (c.src || c.drv)) e_db = c.x2d;
      check_v($sformatf("dbus_out ph%0d pc=%h", p, c.pc), 8'(bus_if.dbus_out), 8'(e_db));
      check_b($sformatf("cm_rom ph%0d", p), bus_if.cm_rom,
              (p == 4 && c.valid && c.io) || (p == 6 && c.valid && c.src));
      check_b($sformatf("sync ph%0d", p), bus_if.sync, p == 7);
      check_b($sformatf("cmd_ready ph%0d", p), bus_if.cmd_ready, p == 7);
      check_b($sformatf("cl_rom ph%0d", p), bus_if.cl_rom, c.clr && p < CLR_CYCLES);
      check_b($sformatf("rsp_valid ph%0d", p), bus_if.rsp_valid, p == 7 && c.valid);
      if (p == 0) begin
        junk = mkc(1'b0, 12'($urandom_range(4095)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)), c.io_in);
        drive(junk);
      end
      if (p == 6) drive(mkc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, c.io_in));
    end
    if (c.valid) begin
      m_op = e_op;
      m_x2 = e_x2;
    end
    if (wrr) m_io_out = e_x2 & IO_MASK;
    if (c.valid && c.src) m_sel = e_x2;
    check_v("rsp_opcode model", bus_if.rsp_opcode, m_op);
    check_v("rsp_x2_data model", 8'(bus_if.rsp_x2_data), 8'(m_x2));
    check_v("io_out model", 8'(io_out), 8'(m_io_out));
  endtask

  initial begin
    vec_t tbl [8];
    cmd_t c;
    n_vec = 0; n_err = 0;
    m_op = 8'h00; m_x2 = 4'h0; m_sel = 4'h0; m_io_out = 4'h0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(255));
    rom[8'hA5] = 8'h3C;
    rom[8'h20] = 8'h5B;
    rom[8'h10] = 8'hE0;
    rom[8'h11] = 8'hEA;

    tbl[0] = mkv(mkc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0), 8'h00, 4'h0, 4'h0);
    tbl[1] = mkv(mkc(1'b1, 12'h0A5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0), 8'h3C, 4'h0, 4'h0);
    tbl[2] = mkv(mkc(1'b1, 12'h020, 1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 4'h0), 8'h5B, 4'h2, 4'h0);
    tbl[3] = mkv(mkc(1'b1, 12'h010, 1'b1, 1'b0, 1'b1, 4'h9, 1'b0, 4'h0), 8'hE0, 4'h9, 4'h9);
    tbl[4] = mkv(mkc(1'b1, 12'h011, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h6), 8'hEA, 4'h6, 4'h9);
    tbl[5] = mkv(mkc(1'b1, 12'h0A5, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 4'h0), 8'h3C, 4'h7, 4'h9);
    tbl[6] = mkv(mkc(1'b0, 12'h0A5, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0), 8'h3C, 4'h7, 4'h9);
    tbl[7] = mkv(mkc(1'b1, 12'h1A5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0), 8'h00, 4'h0, 4'h9);

    rst_n = 1'b0;
    drive(mkc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0));
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) do_cycle(tbl[0].c);

    for (int i = 0; i < 8; i++) begin
      do_cycle(tbl[i].c);
      check_v($sformatf("tbl%0d rsp_opcode", i), bus_if.rsp_opcode, tbl[i].op);
      check_v($sformatf("tbl%0d rsp_x2_data", i), 8'(bus_if.rsp_x2_data), 8'(tbl[i].x2));
      check_v($sformatf("tbl%0d io_out", i), 8'(io_out), 8'(tbl[i].ioo));
    end

    // clr_req held through the pulse must not stretch or restart it.
    drive(mkc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0));
    for (int p = 0; p < 8; p++) begin
      @(posedge clk);
      @(negedge clk);
      check_b($sformatf("clr hold cl_rom ph%0d", p), bus_if.cl_rom, p < CLR_CYCLES);
      if (p == 6) bus_if.clr_req = 1'b0;
    end
    do_cycle(tbl[0].c);

    // Reset asserted in M1 of an active cycle aborts it.
    drive(mkc(1'b1, 12'h0A5, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 4'h0));
    @(posedge clk);
    @(negedge clk);
    drive(mkc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0));
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("async reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("held reset");
    m_op = 8'h00; m_x2 = 4'h0; m_sel = 4'h0; m_io_out = 4'h0;
    rst_n = 1'b1;
    do_cycle(tbl[0].c);
    do_cycle(tbl[1].c);

    for (int i = 0; i < 40; i++) begin
      c = mkc($urandom_range(3) != 0,
              {($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'h0, 8'($urandom_range(255))},
              1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              4'($urandom_range(15)), $urandom_range(3) == 0, 4'($urandom_range(15)));
      do_cycle(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mcs4_bus_master.md
Name: mcs4_bus_master

Overview:
- Upstream bus sequencer for the MCS-4 ROM/IO chips: the CPU-side timing and bus engine that drives the shared 4-bit data bus.
- Generates the 8-phase instruction cycle (A1,A2,A3,M1,M2,X1,X2,X3) and `sync`.
- Drives the 12-bit fetch address, captures the 8-bit opcode, and issues the control strobes: `cm_rom` for I/O selection and SRC, `cl_rom` for clear.
- The core sees a simple per-instruction-cycle command/response handshake.

Parameters:
- IDLE_ADDR, 12'hFFF, address driven in A1..A3 during idle (no-command) cycles.
- CLR_CYCLES, 1, number of clocks `cl_rom` stays high per clear request (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sync  out  1  high during phase X3; the next clock is A1
- cl_rom  out  1  ROM/IO clear strobe
- cm_rom  out  1  command line to ROMs
- dbus_out  out  4  nibble the master drives onto the bus (0 when not driving)
- dbus_in  in  4  resolved bus (OR of all chip `dbus_out` plus master)
- cmd_valid  in  1  core offers a command for the next instruction cycle
- cmd_ready  out  1  high during X3; a command is accepted when cmd_valid && cmd_ready
- cmd_pc  in  12  fetch address
- cmd_io  in  1  assert `cm_rom` in M2 (I/O instruction: WRR/RDR)
- cmd_src  in  1  assert `cm_rom` in X2 and drive chip-select nibble
- cmd_x2_drive  in  1  drive `cmd_x2_data` in X2 (write data)
- cmd_x2_data  in  4  X2 nibble (write data or chip select)
- rsp_valid  out  1  one-clock pulse with the cycle's results
- rsp_opcode  out  8  {M1 nibble, M2 nibble}
- rsp_x2_data  out  4  `dbus_in` sampled at the end of X2
- clr_req  in  1  request `cl_rom` pulse (level, sampled at X3)

Behaviour:
- **Phase counter:** 3 bits, A1=0 .. X3=7, increments every clock and wraps X3->A1. Reset value X3, so `sync`=1 and `cmd_ready`=1 while `rst_n` is low.
- **Reset values:** `cl_rom`=0, `cm_rom`=0, `dbus_out`=0, `rsp_valid`=0, `rsp_opcode`=0, `rsp_x2_data`=0, internal command register = idle.
- **Reset behaviour:** reset is asynchronous. Assertion mid-cycle aborts the cycle with no `rsp_valid`. The first clock after release enters A1.
- **Command latch:** at the X3 clock edge, if `cmd_valid`, latch pc/io/src/x2_drive/x2_data and mark the cycle active; otherwise mark it idle. Command inputs are ignored in all other phases.
- **`dbus_out` per phase (combinational decode of phase + latched command):**
  - A1 = pc[3:0]
  - A2 = pc[7:4]
  - A3 = pc[11:8]
  - X2 = x2_data if (src || x2_drive), else 0
  - all other phases 0
  - Idle cycles use IDLE_ADDR in A1..A3 and drive 0 in X2.
- **`cm_rom`:**
  - high in M2 iff active && io.
  - high in X2 iff active && src.
  - 0 otherwise.
  - io and src may both be set; each acts in its own phase.
- **Captures:**
  - at the M1 clock edge, opcode[7:4] <= dbus_in.
  - at M2, opcode[3:0] <= dbus_in.
  - at X2, x2 <= dbus_in. The master's own X2 drive is visible here.
- **Response:** `rsp_valid`=1 for exactly the X3 clock of active cycles, with `rsp_opcode`/`rsp_x2_data` stable from X3 until the next X3. Idle cycles produce no `rsp_valid` and leave the outputs unchanged.
- **Latency:**
  - command accepted at X3 of cycle N
  - address on bus in cycle N+1
  - `rsp_valid` in X3 of cycle N+1 (8 clocks after acceptance)
  - back-to-back commands every 8 clocks with no bubble.
- **Clear:**
  - `clr_req` sampled at the X3 edge starts a down-counter; `cl_rom` is high for CLR_CYCLES clocks starting at A1.
  - A new `clr_req` while counting is ignored.
  - Clear does not alter bus sequencing.
- **Ready:** `cmd_ready` = (phase==X3); no back-pressure otherwise.

Test Plan:
1. Reset release, `cmd_valid`=0 -> `sync` pulses every 8 clocks. Idle cycles drive F,F,F in A1..A3. No `rsp_valid`.
2. cmd pc=12'h0A5, 4001 model ROM_ID=0 with rom[0xA5]=8'h3C -> bus shows 5,A,0 in A1..A3. `rsp_opcode`=8'h3C, `rsp_valid` 8 clocks after acceptance.
3. cmd src=1, x2_data=4'h2 -> `cm_rom` high only in X2, `dbus_out`=2 in X2. Next cmd io=1 with ROM M2 nibble=WRR, x2_drive=1, x2_data=4'h9 -> `cm_rom` high in M2; the ROM chip 2 `io_out` updates at X2 per its IO_MASK.
4. RDR to chip 2 with `io_in`=4'h6, IO_MASK=4'hF -> `rsp_x2_data`=6.
5. `clr_req`=1 at X3 with CLR_CYCLES=3 -> `cl_rom` high for A1..A3 of the next cycle. A second `clr_req` during the pulse is ignored.
6. `rst_n` low during M1 of an active cycle -> outputs go to reset values immediately, no `rsp_valid`, first clock after release is A1.
